// File: rtl/store_checker_pkg.sv
// store_checker_pkg: shared types for the store checker.
//   chk_state_t  - checker state encoding
//   exp_entry_t  - one expected (address, data) store, CHK_WIDTH bits per field
package store_checker_pkg;

    localparam int CHK_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        PASS,
        FAIL,
        TIMEOUT
    } chk_state_t;

    typedef struct packed {
        logic [CHK_WIDTH-1:0] addr;
        logic [CHK_WIDTH-1:0] data;
    } exp_entry_t;

endpackage

// File: rtl/store_checker_table.sv
// store_checker_table: DEPTH-entry register file of expected stores.
//   clk      - rising-edge clock
//   wr_en    - write strobe (already qualified by the caller)
//   wr_idx   - entry written; indices >= DEPTH are dropped
//   wr_entry - entry value written
//   rd_idx   - combinational read index (match counter, may reach DEPTH)
//   rd_entry - entry at rd_idx, or 0 when rd_idx >= DEPTH
// Contents are intentionally not reset.
module store_checker_table
    import store_checker_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IW    = $clog2(DEPTH),
    parameter int RW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  exp_entry_t    wr_entry,
    input  logic [RW-1:0] rd_idx,
    output exp_entry_t    rd_entry
);

    exp_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_idx) < DEPTH)) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    always_comb begin
        rd_entry = '0;
        if (int'(rd_idx) < DEPTH) begin
            rd_entry = mem[rd_idx[IW-1:0]];
        end
    end

endmodule

// File: rtl/store_checker.sv
// store_checker: in-order monitor of the core data-memory write port.
// Compares stores against a programmed table of expected (addr, data)
// pairs, tolerates stores to ALLOW_ADDR and reports pass/fail/timeout.
// Ports:
//   clk, reset (async, active-low)
//   cfg_we/cfg_idx/cfg_addr/cfg_data - table write, honoured only in IDLE
//   cfg_len     - active entry count, sampled (clamped to DEPTH) on start
//   start       - arm pulse (ignored while ARMED)
//   mem_write/data_adr/write_data - observed store port
//   busy/pass/fail/timeout - state decodes
//   match_count - entries matched so far
//   fail_addr/fail_data - offending/last store (capture build only, else 0)
// Build option: define STORE_CHECKER_CAPTURE_EN to enable store capture.
// WIDTH must equal CHK_WIDTH of the package (table entry width).
module store_checker
    import store_checker_pkg::*;
#(
    parameter int WIDTH          = CHK_WIDTH,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 50,
    parameter int ALLOW_ADDR     = 96
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
    input  logic [WIDTH-1:0]           cfg_addr,
    input  logic [WIDTH-1:0]           cfg_data,
    input  logic [$clog2(DEPTH+1)-1:0] cfg_len,
    input  logic                       start,
    input  logic                       mem_write,
    input  logic [WIDTH-1:0]           data_adr,
    input  logic [WIDTH-1:0]           write_data,
    output logic                       busy,
    output logic                       pass,
    output logic                       fail,
    output logic                       timeout,
    output logic [$clog2(DEPTH+1)-1:0] match_count,
    output logic [WIDTH-1:0]           fail_addr,
    output logic [WIDTH-1:0]           fail_data
);

    localparam int IW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    chk_state_t    state, state_nx;
    logic [LW-1:0] count, count_nx;
    logic [LW-1:0] len, len_nx;
    logic [LW-1:0] len_clamp;
    logic [TW-1:0] timer, timer_nx, timer_inc;
    exp_entry_t    cur;
    exp_entry_t    wr_entry;
    logic          hit;

    assign wr_entry = '{addr: cfg_addr, data: cfg_data};

    store_checker_table #(
        .DEPTH (DEPTH),
        .IW    (IW),
        .RW    (LW)
    ) u_table (
        .clk      (clk),
        .wr_en    (cfg_we && (state == IDLE)),
        .wr_idx   (cfg_idx),
        .wr_entry (wr_entry),
        .rd_idx   (count),
        .rd_entry (cur)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            len   <= '0;
            timer <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            len   <= len_nx;
            timer <= timer_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        count_nx  = count;
        len_nx    = len;
        timer_nx  = timer;
        len_clamp = (int'(cfg_len) > DEPTH) ? LW'(DEPTH) : cfg_len;
        timer_inc = (int'(timer) >= TIMEOUT_CYCLES) ? timer : timer + 1'b1;
        hit       = mem_write && (data_adr == cur.addr) && (write_data == cur.data);

        case (state)
            ARMED: begin
                timer_nx = timer_inc;
                if (hit) begin
                    count_nx = count + 1'b1;
                    if (count_nx == len) begin
                        state_nx = PASS;
                    end
                end else if (mem_write) begin
                    // ALLOW_ADDR is only tolerated when it is not the expected
                    // address; a data mismatch on the expected address fails.
                    if ((data_adr != WIDTH'(ALLOW_ADDR)) || (data_adr == cur.addr)) begin
                        state_nx = FAIL;
                    end
                end
                // Completion or failure outranks timer expiry.
                if ((state_nx == ARMED) && (int'(timer_inc) >= TIMEOUT_CYCLES)) begin
                    state_nx = TIMEOUT;
                end
            end
            default: begin
                if (start) begin
                    len_nx   = len_clamp;
                    count_nx = '0;
                    timer_nx = '0;
                    state_nx = (len_clamp == '0) ? PASS : ARMED;
                end
            end
        endcase
    end

    assign busy        = (state == ARMED);
    assign pass        = (state == PASS);
    assign fail        = (state == FAIL);
    assign timeout     = (state == TIMEOUT);
    assign match_count = count;

`ifdef STORE_CHECKER_CAPTURE_EN
    logic [WIDTH-1:0] cap_addr, cap_data;

    // Every store seen while ARMED is captured, so on FAIL this is the
    // offending store and on TIMEOUT it is the last store observed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_addr <= '0;
            cap_data <= '0;
        end else if ((state != ARMED) && start) begin
            cap_addr <= '0;
            cap_data <= '0;
        end else if ((state == ARMED) && mem_write) begin
            cap_addr <= data_adr;
            cap_data <= write_data;
        end
    end

    assign fail_addr = cap_addr;
    assign fail_data = cap_data;
`else
    assign fail_addr = '0;
    assign fail_data = '0;
`endif

endmodule

// File: doc/store_checker.md
Name: store_checker

Overview:
- Synthesizable on-chip monitor for the processor data-memory write port (mem_write / data_adr / write_data).
- Checks stores in order against a programmable table of up to DEPTH expected (address, data) pairs.
- Tolerates one scratch address and flags pass, fail or timeout.
- Sits beside the core in self-checking system tops, so simulation and FPGA runs share one pass/fail source.

Parameters:
- WIDTH, 32, width of address and data buses
- DEPTH, 4, number of expected-store table entries
- TIMEOUT_CYCLES, 50, armed cycles allowed before timeout
- ALLOW_ADDR, 96, store address tolerated without affecting the check

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- cfg_we  input  1  table write strobe, accepted only in IDLE
- cfg_idx  input  $clog2(DEPTH)  table entry index
- cfg_addr  input  WIDTH  expected store address
- cfg_data  input  WIDTH  expected store data
- cfg_len  input  $clog2(DEPTH+1)  active entries, sampled on start
- start  input  1  arm pulse
- mem_write  input  1  store strobe from core
- data_adr  input  WIDTH  store address
- write_data  input  WIDTH  store data
- busy  output  1  state is ARMED
- pass  output  1  all active entries matched
- fail  output  1  unexpected store seen
- timeout  output  1  timeout expired before completion
- match_count  output  $clog2(DEPTH+1)  entries matched so far
- fail_addr  output  WIDTH  address of offending store
- fail_data  output  WIDTH  data of offending store

Behaviour:
- Reset (reset=0):
  - State IDLE; all outputs 0; index, timer and len register cleared.
  - Table contents are not reset.
- States: IDLE, ARMED, PASS, FAIL, TIMEOUT.
  - pass, fail, timeout and busy are registered decodes of the state; they are 1 exactly when the state is PASS, FAIL, TIMEOUT or ARMED respectively.
- IDLE:
  - cfg_we writes entry cfg_idx in the same cycle; writes with cfg_idx >= DEPTH are ignored.
  - start latches len = min(cfg_len, DEPTH), clears match_count and the timer, then goes to ARMED.
  - If len = 0, go directly to PASS.
- ARMED, each rising edge:
  - Timer increments, saturating at TIMEOUT_CYCLES.
  - If mem_write=1:
    - data_adr equals entry[match_count].addr and write_data equals entry[match_count].data: match_count++; if the new count equals len, go to PASS.
    - Else if data_adr == ALLOW_ADDR: ignored, no state change.
    - Else: go to FAIL.
  - If no transition is taken and the timer reaches TIMEOUT_CYCLES, go to TIMEOUT.
  - A final match in the same cycle the timer expires goes to PASS; a completion event outranks timeout.
  - Address match with data mismatch is FAIL, even when the address equals ALLOW_ADDR and matches an entry.
  - Only the expected-entry check uses data; ALLOW_ADDR stores are ignored regardless of data.
- PASS / FAIL / TIMEOUT:
  - Sticky. mem_write is ignored.
  - cfg_we is ignored; the table is writable only in IDLE.
  - start re-arms: same actions as from IDLE, using the current cfg_len.
  - start in ARMED is ignored.
- Latency: a store sampled at edge N is reflected on the outputs after edge N, visible in cycle N+1.
- Reset asserted mid-run aborts to IDLE immediately (asynchronous).
- Widths: all comparisons are full WIDTH, unsigned; match_count never exceeds len.

Optional Feature:
- STORE_CHECKER_CAPTURE_EN defined:
  - On the transition to FAIL, fail_addr/fail_data capture data_adr/write_data of the offending store.
  - Values hold until the next start or reset.
  - On TIMEOUT they hold the last store seen while ARMED, or 0 if none.
- Undefined: fail_addr and fail_data are constant 0 and no capture registers exist.

Decomposition:
- Package store_checker_pkg:
  - state enum chk_state_t {IDLE, ARMED, PASS, FAIL, TIMEOUT}
  - struct exp_entry_t {addr, data}, parameterised via WIDTH localparam default 32
- One sub-module: store_checker_table, a DEPTH x exp_entry_t register file with one write port and one combinational read port indexed by match_count.
- FSM and timer stay in the top module.

Test Plan:
- Basic pass: DEPTH=4, cfg_len=1, entry0=(100,7); start; stores (96,x) then (100,7) -> pass=1 the cycle after the second store, match_count=1, fail=0.
- Bad address: entry0=(100,7); store (104,7) -> fail=1; with STORE_CHECKER_CAPTURE_EN, fail_addr=104, fail_data=7.
- Ordered sequence: cfg_len=3, entries (100,7),(104,8),(108,9); stores in order -> pass after the third; swapping the 2nd and 3rd stores -> fail at (108,9).
- Timeout: TIMEOUT_CYCLES=50, no stores after start -> timeout=1 exactly 50 edges after ARMED entry. Final matching store on edge 50 -> pass=1, timeout=0.
- Reset/rearm: assert reset mid-ARMED -> all outputs 0 asynchronously. From PASS, start with cfg_len=0 -> pass re-asserted next cycle, match_count=0.
- Config guard: cfg_we while ARMED with new entry0 data -> ignored; the original entry still required for pass.
